// File: rtl/spike_out_pktzr.sv
// -----------------------------------------------------------------------------
// spike_out_pktzr
//
// Output spike packetiser between the neuron unit and the router. Every
// outSpike_i strobe captures SpikeAER_i into a small first-word-fall-through
// FIFO, which is drained towards the router over a valid/ready handshake.
// Spikes that find the FIFO full (with no pop in the same cycle) are dropped
// and counted. The number of spikes accepted per time step is reported at
// each start_i pulse.
//
// Ports:
//   clk_i        - clock, rising edge active
//   rst_n_i      - asynchronous active-low reset
//   start_i      - time-step start pulse (closes the current step statistics)
//   outSpike_i   - one-cycle spike strobe from the neuron datapath
//   SpikeAER_i   - AER packet of the firing neuron, valid with outSpike_i
//   pktData_o    - head-of-FIFO packet towards the router
//   pktValid_o   - pktData_o holds a valid packet
//   pktReady_i   - router accepts pktData_o this cycle
//   fifoFull_o   - FIFO holds FIFO_DEPTH packets
//   fifoEmpty_o  - FIFO holds no packets
//   dropCnt_o    - spikes lost to overflow since reset (saturating)
//   stepSpkCnt_o - spikes accepted during the last completed time step
// -----------------------------------------------------------------------------
module spike_out_pktzr #(
   parameter int AER_BIT_WIDTH      = 32,
   parameter int FIFO_DEPTH         = 4,
   parameter int FIFO_PTR_BIT_WIDTH = 2,
   parameter int CNT_BIT_WIDTH      = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     start_i,
   input  logic                     outSpike_i,
   input  logic [AER_BIT_WIDTH-1:0] SpikeAER_i,
   output logic [AER_BIT_WIDTH-1:0] pktData_o,
   output logic                     pktValid_o,
   input  logic                     pktReady_i,
   output logic                     fifoFull_o,
   output logic                     fifoEmpty_o,
   output logic [CNT_BIT_WIDTH-1:0] dropCnt_o,
   output logic [CNT_BIT_WIDTH-1:0] stepSpkCnt_o
);

   // Occupancy value meaning "full", sized to the occupancy counter.
   localparam logic [FIFO_PTR_BIT_WIDTH:0] OCC_FULL = (FIFO_PTR_BIT_WIDTH+1)'(FIFO_DEPTH);

   // Saturating increment shared by all statistics counters.
   function automatic logic [CNT_BIT_WIDTH-1:0] sat_inc(input logic [CNT_BIT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [AER_BIT_WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [FIFO_PTR_BIT_WIDTH-1:0] wr_ptr;
   logic [FIFO_PTR_BIT_WIDTH-1:0] rd_ptr;
   logic [FIFO_PTR_BIT_WIDTH:0]   occ;
   logic [CNT_BIT_WIDTH-1:0]      drop_cnt;
   logic [CNT_BIT_WIDTH-1:0]      acc_cnt;
   logic [CNT_BIT_WIDTH-1:0]      step_cnt;

   logic full;
   logic pop;
   logic push;
   logic drop;

   // Handshake decode from registered occupancy.
   assign full = (occ == OCC_FULL);
   assign pop  = pktValid_o & pktReady_i;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push = outSpike_i & (~full | pop);
   assign drop = outSpike_i & full & ~pop;

   assign pktValid_o   = (occ != '0);
   assign pktData_o    = mem[rd_ptr];
   assign fifoFull_o   = full;
   assign fifoEmpty_o  = (occ == '0);
   assign dropCnt_o    = drop_cnt;
   assign stepSpkCnt_o = step_cnt;

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= SpikeAER_i;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            occ <= occ + 1'b1;
         end else if (pop && !push) begin
            occ <= occ - 1'b1;
         end
      end
   end

   // Drop and per-step statistics.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         drop_cnt <= '0;
         acc_cnt  <= '0;
         step_cnt <= '0;
      end else begin
         if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
         end
         if (start_i) begin
            // A spike coinciding with start_i is the first of the new step.
            step_cnt <= acc_cnt;
            acc_cnt  <= push ? CNT_BIT_WIDTH'(1) : '0;
         end else if (push) begin
            acc_cnt <= sat_inc(acc_cnt);
         end
      end
   end

endmodule
